// File: rtl/pc_redirect_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit_pkg
//
// Purpose : Shared definitions for the RV32 front-end control blocks.
//           Holds the branch func3 codes used by the branch control unit, the
//           PC redirect unit state encoding and its reset/trap vector defaults.
//
// Contents:
//   BR_*               - conditional branch func3 encodings
//   pcr_state_e        - PC redirect unit FSM states (PCR_RUN, PCR_HALT)
//   PCR_RESET_PC       - default PC loaded at reset
//   PCR_TRAP_VEC       - default PC loaded on a misaligned-target trap
//   pcr_add32()        - 32-bit wrapping add used for all PC arithmetic
// -----------------------------------------------------------------------------
package pc_redirect_unit_pkg;

  // Conditional branch func3 codes (RV32I B-type).
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // PC redirect unit state machine.
  typedef enum logic [0:0] {
    PCR_RUN  = 1'b0,
    PCR_HALT = 1'b1
  } pcr_state_e;

  // Reset and trap vector defaults for pc_redirect_unit.
  localparam logic [31:0] PCR_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PCR_TRAP_VEC = 32'h0000_0004;

  // All PC arithmetic is modulo 2^32; the carry out is intentionally dropped.
  function automatic logic [31:0] pcr_add32(input logic [31:0] a,
                                            input logic [31:0] b);
    return a + b;
  endfunction

endpackage : pc_redirect_unit_pkg

// File: rtl/pc_redirect_unit_if.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit_if
//
// Purpose : Bundles the EX-stage control inputs and the fetch-side outputs of
//           pc_redirect_unit. There is no valid/ready handshake on this bus:
//           every EX input is sampled on each rising clock edge as a level,
//           and every output is either a register or a combinational function
//           of the current inputs and state.
//
// Signals (direction as seen by the redirect unit, i.e. the slave modport):
//   in  stall, ex_branch, branch, ex_jal, ex_jalr, ex_halt, resume
//   in  ex_pc[31:0], ex_imm[31:0], ex_rs1[31:0]
//   out pc[31:0], pc_plus4[31:0], flush_if_id, flush_id_ex
//   out trap_valid, trap_tval[31:0], halted, redirect_cnt[31:0]
//   out dbg_state (FSM state, for observation only)
//
// Modports:
//   master - the pipeline side that drives EX information and consumes PC
//   slave  - the redirect unit itself
// -----------------------------------------------------------------------------
interface pc_redirect_unit_if;
  import pc_redirect_unit_pkg::*;

  // EX-stage / hazard inputs
  logic        stall;
  logic        ex_branch;
  logic        branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic        ex_halt;
  logic        resume;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;

  // Fetch-side outputs
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        trap_valid;
  logic [31:0] trap_tval;
  logic        halted;
  logic [31:0] redirect_cnt;
  pcr_state_e  dbg_state;

  modport master (
    output stall, ex_branch, branch, ex_jal, ex_jalr, ex_halt, resume,
    output ex_pc, ex_imm, ex_rs1,
    input  pc, pc_plus4, flush_if_id, flush_id_ex,
    input  trap_valid, trap_tval, halted, redirect_cnt, dbg_state
  );

  modport slave (
    input  stall, ex_branch, branch, ex_jal, ex_jalr, ex_halt, resume,
    input  ex_pc, ex_imm, ex_rs1,
    output pc, pc_plus4, flush_if_id, flush_id_ex,
    output trap_valid, trap_tval, halted, redirect_cnt, dbg_state
  );

endinterface : pc_redirect_unit_if

// File: rtl/pc_redirect_unit_target_gen.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit_target_gen
//
// Purpose : Combinational redirect target generation for the EX stage.
//           Selects between the PC-relative target (branch, JAL) and the
//           register-relative target (JALR, with bit 0 cleared), decides
//           whether a redirect is taken and flags misaligned targets.
//
// Ports:
//   ex_branch_i   - EX instruction is a conditional branch
//   branch_i      - branch taken decision (meaningful only with ex_branch_i)
//   ex_jal_i      - EX instruction is JAL
//   ex_jalr_i     - EX instruction is JALR
//   ex_pc_i       - PC of the EX instruction
//   ex_imm_i      - sign-extended immediate of the EX instruction
//   ex_rs1_i      - rs1 operand (JALR base)
//   take_o        - a redirect is requested this cycle
//   target_o      - redirect target address
//   misaligned_o  - take_o with target bit 1 set
// -----------------------------------------------------------------------------
module pc_redirect_unit_target_gen
  import pc_redirect_unit_pkg::*;
(
  input  logic        ex_branch_i,
  input  logic        branch_i,
  input  logic        ex_jal_i,
  input  logic        ex_jalr_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] ex_rs1_i,
  output logic        take_o,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  logic [31:0] pc_rel_tgt;
  logic [31:0] reg_rel_sum;
  logic [31:0] reg_rel_tgt;

  assign pc_rel_tgt  = pcr_add32(ex_pc_i, ex_imm_i);
  assign reg_rel_sum = pcr_add32(ex_rs1_i, ex_imm_i);
  assign reg_rel_tgt = reg_rel_sum & ~32'h1;

  // Only JALR uses the register-relative target. If several jump inputs are
  // raised together, JALR wins; JAL and branch share the same target, so the
  // JAL-over-branch priority needs no separate mux leg.
  assign target_o = ex_jalr_i ? reg_rel_tgt : pc_rel_tgt;

  assign take_o = (ex_branch_i & branch_i) | ex_jal_i | ex_jalr_i;

  // Targets must be 4-byte aligned; bit 0 of a JALR target is already cleared
  // and bit 0 of a branch/JAL target is always zero for legal immediates, so
  // only bit 1 is inspected.
  assign misaligned_o = take_o & target_o[1];

endmodule : pc_redirect_unit_target_gen

// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//
// Purpose : Fetch program counter and next-PC selection for the RV32
//           pipeline. Consumes the EX-stage branch/jump/halt indications,
//           redirects fetch, flushes wrong-path instructions in IF/ID and
//           ID/EX, raises a one-cycle trap on misaligned targets and holds the
//           core in a HALT state until resume.
//
// Parameters:
//   RESET_PC - PC loaded at reset
//   TRAP_VEC - PC loaded on a misaligned-target trap
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   pcr   - pc_redirect_unit_if.slave bundle (EX inputs, PC/flush/trap/status
//           outputs, dbg_state)
//
// Priority in RUN (highest first): halt, misaligned trap, taken redirect,
// stall, sequential fetch. The EX instruction is older than anything being
// stalled behind it, so halt/trap/redirect all override stall.
// -----------------------------------------------------------------------------
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PCR_RESET_PC,
  parameter logic [31:0] TRAP_VEC = PCR_TRAP_VEC
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_redirect_unit_if.slave pcr
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pcr_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        trap_valid_q, trap_valid_d;
  logic [31:0] trap_tval_q, trap_tval_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  logic        flush;
  logic [31:0] pc_plus4;
  logic [31:0] halt_pc;

  // ---------------------------------------------------------------------------
  // Target generation
  // ---------------------------------------------------------------------------
  logic        take;
  logic [31:0] target;
  logic        misaligned;

  pc_redirect_unit_target_gen u_target_gen (
    .ex_branch_i  (pcr.ex_branch),
    .branch_i     (pcr.branch),
    .ex_jal_i     (pcr.ex_jal),
    .ex_jalr_i    (pcr.ex_jalr),
    .ex_pc_i      (pcr.ex_pc),
    .ex_imm_i     (pcr.ex_imm),
    .ex_rs1_i     (pcr.ex_rs1),
    .take_o       (take),
    .target_o     (target),
    .misaligned_o (misaligned)
  );

  assign pc_plus4 = pcr_add32(pc_q, 32'd4);
  // Fetch resumes after the halting instruction, not after the current PC.
  assign halt_pc  = pcr_add32(pcr.ex_pc, 32'd4);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_plus4;
    flush          = 1'b0;
    trap_valid_d   = 1'b0;
    trap_tval_d    = trap_tval_q;
    redirect_cnt_d = redirect_cnt_q;

    case (state_q)
      PCR_RUN: begin
        if (pcr.ex_halt) begin
          pc_d    = halt_pc;
          flush   = 1'b1;
          state_d = PCR_HALT;
        end else if (misaligned) begin
          // Traps replace the redirect entirely and are not counted.
          pc_d         = TRAP_VEC;
          flush        = 1'b1;
          trap_valid_d = 1'b1;
          trap_tval_d  = target;
        end else if (take) begin
          pc_d           = target;
          flush          = 1'b1;
          redirect_cnt_d = pcr_add32(redirect_cnt_q, 32'd1);
        end else if (pcr.stall) begin
          pc_d = pc_q;
        end
      end

      PCR_HALT: begin
        // EX inputs are ignored here. Flushes stay high through the resume
        // cycle so nothing fetched while halted leaks into the pipeline; the
        // first RUN cycle after resume is flush-free and fetches from pc_q.
        pc_d  = pc_q;
        flush = 1'b1;
        if (pcr.resume) begin
          state_d = PCR_RUN;
        end
      end

      default: begin
        state_d = PCR_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PCR_RUN;
      pc_q           <= RESET_PC;
      trap_valid_q   <= 1'b0;
      trap_tval_q    <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      trap_valid_q   <= trap_valid_d;
      trap_tval_q    <= trap_tval_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pcr.pc           = pc_q;
  assign pcr.pc_plus4     = pc_plus4;
  assign pcr.flush_if_id  = flush;
  assign pcr.flush_id_ex  = flush;
  assign pcr.trap_valid   = trap_valid_q;
  assign pcr.trap_tval    = trap_tval_q;
  assign pcr.halted       = (state_q == PCR_HALT);
  assign pcr.redirect_cnt = redirect_cnt_q;
  assign pcr.dbg_state    = state_q;

endmodule : pc_redirect_unit

// File: tb/tb_pc_redirect_unit.sv
`timescale 1ns/1ps
module tb_pc_redirect_unit;
  import pc_redirect_unit_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  pc_redirect_unit_if bus();

  pc_redirect_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pcr   (bus)
  );

  // ---------------------------------------------------------------------------
  // Reference model state (architectural view only)
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc, m_cnt, m_tval;
  logic        m_halted, m_trapv;

  function automatic logic m_take();
    return (bus.ex_branch && bus.branch) || bus.ex_jal || bus.ex_jalr;
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] s;
    if (bus.ex_jalr) begin
      s = bus.ex_rs1 + bus.ex_imm;
      return s - (s % 2);
    end
    return bus.ex_pc + bus.ex_imm;
  endfunction

  function automatic logic m_misaligned();
    logic [31:0] t;
    t = m_target();
    return m_take() && ((t / 2) % 2 == 1);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_cnt = 32'h0; m_tval = 32'h0; m_halted = 1'b0; m_trapv = 1'b0;
  endtask

  // Called right after a rising edge, while the sampled inputs are still held.
  task automatic model_step();
    m_trapv = 1'b0;
    if (m_halted) begin
      if (bus.resume) m_halted = 1'b0;
    end else if (bus.ex_halt) begin
      m_pc = bus.ex_pc + 4;
      m_halted = 1'b1;
    end else if (m_misaligned()) begin
      m_tval = m_target();
      m_pc = 32'h4;
      m_trapv = 1'b1;
    end else if (m_take()) begin
      m_pc = m_target();
      m_cnt = m_cnt + 1;
    end else if (!bus.stall) begin
      m_pc = m_pc + 4;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    bus.stall = 0; bus.ex_branch = 0; bus.branch = 0; bus.ex_jal = 0;
    bus.ex_jalr = 0; bus.ex_halt = 0; bus.resume = 0;
    bus.ex_pc = 0; bus.ex_imm = 0; bus.ex_rs1 = 0;
  endtask

  // Advance one clock: returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    vectors++; if (bus.pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    vectors++; if (bus.trap_valid !== 1'b0) begin miscompares++; $display("FAIL reset_trap_valid: got %b want 0", bus.trap_valid); end
    vectors++; if (bus.trap_tval !== 32'h0) begin miscompares++; $display("FAIL reset_tval: got %h want 0", bus.trap_tval); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.pc !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, 32'(i * 4)); end
      vectors++; if (bus.redirect_cnt !== 32'h0) begin miscompares++; $display("FAIL seq_cnt[%0d]: got %h want 0", i, bus.redirect_cnt); end
      tick();
    end
    // pc is now 0x10
  endtask

  task automatic test_branch();
    bus.ex_branch = 1; bus.branch = 1; bus.ex_pc = 32'h100; bus.ex_imm = 32'h20;
    #1;
    vectors++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) begin miscompares++; $display("FAIL br_flush: got %b%b want 11", bus.flush_if_id, bus.flush_id_ex); end
    tick();
    clear_inputs();
    vectors++; if (bus.pc !== 32'h120) begin miscompares++; $display("FAIL br_pc: got %h want %h", bus.pc, 32'h120); end
    vectors++; if (bus.redirect_cnt !== 32'h1) begin miscompares++; $display("FAIL br_cnt: got %h want 1", bus.redirect_cnt); end
    bus.ex_branch = 1; bus.branch = 0; bus.ex_pc = 32'h100; bus.ex_imm = 32'h20;
    #1;
    vectors++; if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) begin miscompares++; $display("FAIL nt_flush: got %b%b want 00", bus.flush_if_id, bus.flush_id_ex); end
    tick();
    clear_inputs();
    vectors++; if (bus.pc !== 32'h124) begin miscompares++; $display("FAIL nt_pc: got %h want %h", bus.pc, 32'h124); end
  endtask

  task automatic test_jalr_trap();
    bus.ex_jalr = 1; bus.ex_rs1 = 32'h203; bus.ex_imm = 32'h0;
    #1;
    vectors++; if (bus.flush_if_id !== 1'b1) begin miscompares++; $display("FAIL trap_flush: got %b want 1", bus.flush_if_id); end
    tick();
    clear_inputs();
    vectors++; if (bus.pc !== 32'h4) begin miscompares++; $display("FAIL trap_pc: got %h want %h", bus.pc, 32'h4); end
    vectors++; if (bus.trap_valid !== 1'b1) begin miscompares++; $display("FAIL trap_valid: got %b want 1", bus.trap_valid); end
    vectors++; if (bus.trap_tval !== 32'h202) begin miscompares++; $display("FAIL trap_tval: got %h want %h", bus.trap_tval, 32'h202); end
    vectors++; if (bus.redirect_cnt !== 32'h1) begin miscompares++; $display("FAIL trap_cnt: got %h want 1", bus.redirect_cnt); end
    tick();
    vectors++; if (bus.trap_valid !== 1'b0) begin miscompares++; $display("FAIL trap_pulse: got %b want 0", bus.trap_valid); end
    vectors++; if (bus.trap_tval !== 32'h202) begin miscompares++; $display("FAIL trap_tval_hold: got %h want %h", bus.trap_tval, 32'h202); end
    vectors++; if (bus.pc !== 32'h8) begin miscompares++; $display("FAIL trap_next_pc: got %h want %h", bus.pc, 32'h8); end
    bus.ex_jalr = 1; bus.ex_rs1 = 32'h201; bus.ex_imm = 32'h0;
    tick();
    clear_inputs();
    vectors++; if (bus.pc !== 32'h200) begin miscompares++; $display("FAIL jalr_pc: got %h want %h", bus.pc, 32'h200); end
    vectors++; if (bus.trap_valid !== 1'b0) begin miscompares++; $display("FAIL jalr_notrap: got %b want 0", bus.trap_valid); end
    vectors++; if (bus.redirect_cnt !== 32'h2) begin miscompares++; $display("FAIL jalr_cnt: got %h want 2", bus.redirect_cnt); end
  endtask

  task automatic test_stall();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus.flush_if_id !== 1'b0) begin miscompares++; $display("FAIL stall_flush[%0d]: got %b want 0", i, bus.flush_if_id); end
      tick();
      vectors++; if (bus.pc !== 32'h200) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.pc, 32'h200); end
    end
    bus.ex_jal = 1; bus.ex_pc = 32'h40; bus.ex_imm = 32'h10;
    #1;
    vectors++; if (bus.flush_id_ex !== 1'b1) begin miscompares++; $display("FAIL stall_jal_flush: got %b want 1", bus.flush_id_ex); end
    tick();
    clear_inputs();
    vectors++; if (bus.pc !== 32'h50) begin miscompares++; $display("FAIL stall_jal_pc: got %h want %h", bus.pc, 32'h50); end
    vectors++; if (bus.redirect_cnt !== 32'h3) begin miscompares++; $display("FAIL stall_jal_cnt: got %h want 3", bus.redirect_cnt); end
  endtask

  task automatic test_halt();
    bus.ex_halt = 1; bus.ex_jal = 1; bus.ex_pc = 32'h80; bus.ex_imm = 32'h8;
    tick();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      // EX activity while halted must be ignored.
      bus.ex_jal = 1; bus.ex_pc = $urandom; bus.ex_imm = 32'h40; bus.ex_halt = 1;
      #1;
      vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag[%0d]: got %b want 1", i, bus.halted); end
      vectors++; if (bus.pc !== 32'h84) begin miscompares++; $display("FAIL halt_pc[%0d]: got %h want %h", i, bus.pc, 32'h84); end
      vectors++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) begin miscompares++; $display("FAIL halt_flush[%0d]: got %b%b want 11", i, bus.flush_if_id, bus.flush_id_ex); end
      tick();
    end
    clear_inputs();
    bus.resume = 1;
    tick();
    clear_inputs();
    #1;
    vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL resume_flag: got %b want 0", bus.halted); end
    vectors++; if (bus.pc !== 32'h84) begin miscompares++; $display("FAIL resume_pc: got %h want %h", bus.pc, 32'h84); end
    vectors++; if (bus.flush_if_id !== 1'b0) begin miscompares++; $display("FAIL resume_flush: got %b want 0", bus.flush_if_id); end
    tick();
    vectors++; if (bus.pc !== 32'h88) begin miscompares++; $display("FAIL resume_next_pc: got %h want %h", bus.pc, 32'h88); end
    vectors++; if (bus.redirect_cnt !== 32'h3) begin miscompares++; $display("FAIL halt_cnt: got %h want 3", bus.redirect_cnt); end
  endtask

  task automatic test_async_reset();
    bus.ex_halt = 1; bus.ex_pc = 32'h300;
    tick();
    clear_inputs();
    vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL ar_halted: got %b want 1", bus.halted); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.pc !== 32'h0) begin miscompares++; $display("FAIL ar_pc: got %h want 0", bus.pc); end
    vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL ar_halted_clr: got %b want 0", bus.halted); end
    vectors++; if (bus.redirect_cnt !== 32'h0) begin miscompares++; $display("FAIL ar_cnt: got %h want 0", bus.redirect_cnt); end
    vectors++; if (bus.trap_tval !== 32'h0) begin miscompares++; $display("FAIL ar_tval: got %h want 0", bus.trap_tval); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic exp_flush;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 500; n++) begin
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.ex_branch = ($urandom_range(0, 3) == 0);
      bus.branch    = $urandom_range(0, 1) == 1;
      bus.ex_jal    = ($urandom_range(0, 9) == 0);
      bus.ex_jalr   = ($urandom_range(0, 9) == 0);
      bus.ex_halt   = ($urandom_range(0, 24) == 0);
      bus.resume    = ($urandom_range(0, 3) == 0);
      bus.ex_pc     = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.ex_imm    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255) * 4);
      bus.ex_rs1    = $urandom;
      #1;
      exp_flush = m_halted || bus.ex_halt || m_take();
      vectors++; if (bus.pc !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, bus.pc, m_pc); end
      vectors++; if (bus.pc_plus4 !== m_pc + 32'd4) begin miscompares++; $display("FAIL rnd_pc4[%0d]: got %h want %h", n, bus.pc_plus4, m_pc + 32'd4); end
      vectors++; if (bus.flush_if_id !== exp_flush || bus.flush_id_ex !== exp_flush) begin miscompares++; $display("FAIL rnd_flush[%0d]: got %b%b want %b", n, bus.flush_if_id, bus.flush_id_ex, exp_flush); end
      vectors++; if (bus.trap_valid !== m_trapv) begin miscompares++; $display("FAIL rnd_trapv[%0d]: got %b want %b", n, bus.trap_valid, m_trapv); end
      vectors++; if (bus.trap_tval !== m_tval) begin miscompares++; $display("FAIL rnd_tval[%0d]: got %h want %h", n, bus.trap_tval, m_tval); end
      vectors++; if (bus.halted !== m_halted) begin miscompares++; $display("FAIL rnd_halted[%0d]: got %b want %b", n, bus.halted, m_halted); end
      vectors++; if (bus.redirect_cnt !== m_cnt) begin miscompares++; $display("FAIL rnd_cnt[%0d]: got %h want %h", n, bus.redirect_cnt, m_cnt); end
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_branch();
    test_jalr_trap();
    test_stall();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_redirect_unit
